// File: rtl/ccd_line_scheduler.sv
`timescale 1ns/1ps
// Purpose : CCD acquisition sequencer: AFE config handshake, periodic SH trigger, per-line sample framing.
// Latency : every output is registered; event pulses appear in the cycle after the edge that caused them.
// Backpressure: none; samp_valid is consumed every cycle, and the line period is never stretched.
module ccd_line_scheduler #(
  parameter int SAMP_NUM = 2048,
  parameter int PERIOD_W = 24,
  parameter int LINES_W  = 16
) (
  input  logic                sys_clk,
  input  logic                resetn,
  input  logic                run,
  input  logic [PERIOD_W-1:0] line_period,
  input  logic [LINES_W-1:0]  frame_lines,
  input  logic                cfg_req,
  input  logic                cfg_done,
  input  logic                samp_valid,
  output logic                cfg_start,
  output logic                sh_trig,
  output logic                line_open,
  output logic                line_done,
  output logic                frame_done,
  output logic [LINES_W-1:0]  line_cnt,
  output logic                err_overrun,
  output logic                busy
);

  localparam int SAMP_W = $clog2(SAMP_NUM + 1);
  localparam logic [SAMP_W-1:0]   SAMP_LAST  = SAMP_W'(SAMP_NUM - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(2);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                cfg_pend, cfg_pend_nxt;
  logic [PERIOD_W-1:0] period_cnt, period_cnt_nxt;
  logic [PERIOD_W-1:0] period_q, period_q_nxt;
  logic [SAMP_W-1:0]   samp_cnt, samp_cnt_nxt;
  logic                line_open_nxt;
  logic [LINES_W-1:0]  line_cnt_nxt, line_cnt_inc;
  logic                err_nxt;
  logic                sh_nxt, cfg_start_nxt, line_done_nxt, frame_done_nxt;
  logic                last_line;
  logic [PERIOD_W-1:0] period_eff;
  logic                period_end;

  // Short periods are clamped so a line always spans at least two cycles.
  assign period_eff   = (line_period < PERIOD_MIN) ? PERIOD_MIN : line_period;
  assign period_end   = (period_cnt == (period_q - PERIOD_W'(1)));
  assign line_cnt_inc = line_cnt + LINES_W'(1);

  // Next-state and next-output logic; sample accounting is resolved before the
  // trigger so a final sample landing on a wrap closes the old line first.
  always_comb begin
    state_nxt      = state;
    cfg_pend_nxt   = cfg_pend | cfg_req;
    period_cnt_nxt = period_cnt;
    period_q_nxt   = period_q;
    samp_cnt_nxt   = samp_cnt;
    line_open_nxt  = line_open;
    line_cnt_nxt   = line_cnt;
    err_nxt        = err_overrun;
    sh_nxt         = 1'b0;
    cfg_start_nxt  = 1'b0;
    line_done_nxt  = 1'b0;
    frame_done_nxt = 1'b0;
    last_line      = 1'b0;

    if ((state == RUN || state == DRAIN) && samp_valid && line_open) begin
      if (samp_cnt == SAMP_LAST) begin
        line_done_nxt = 1'b1;
        line_cnt_nxt  = line_cnt_inc;
        line_open_nxt = 1'b0;
        samp_cnt_nxt  = '0;
        if (frame_lines != '0 && line_cnt_inc == frame_lines) begin
          frame_done_nxt = 1'b1;
          last_line      = 1'b1;
        end
      end else begin
        samp_cnt_nxt = samp_cnt + SAMP_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (cfg_pend) begin
          state_nxt     = CFG;
          cfg_start_nxt = 1'b1;
          cfg_pend_nxt  = cfg_req;
        end else if (run) begin
          state_nxt      = RUN;
          line_cnt_nxt   = '0;
          err_nxt        = 1'b0;
          period_cnt_nxt = '0;
          period_q_nxt   = period_eff;
          sh_nxt         = 1'b1;
          line_open_nxt  = 1'b1;
          samp_cnt_nxt   = '0;
        end
      end
      CFG: begin
        if (cfg_done) state_nxt = IDLE;
      end
      RUN: begin
        if (last_line) begin
          state_nxt      = IDLE;
          period_cnt_nxt = '0;
        end else if (period_end) begin
          period_cnt_nxt = '0;
          period_q_nxt   = period_eff;
          if (!run || cfg_pend) begin
            state_nxt = DRAIN;
          end else begin
            sh_nxt = 1'b1;
            if (line_open_nxt) err_nxt = 1'b1;
            line_open_nxt = 1'b1;
            samp_cnt_nxt  = '0;
          end
        end else begin
          period_cnt_nxt = period_cnt + PERIOD_W'(1);
        end
      end
      DRAIN: begin
        if (!line_open_nxt) begin
          state_nxt      = IDLE;
          period_cnt_nxt = '0;
        end else if (period_end) begin
          state_nxt      = IDLE;
          err_nxt        = 1'b1;
          line_open_nxt  = 1'b0;
          samp_cnt_nxt   = '0;
          period_cnt_nxt = '0;
        end else begin
          period_cnt_nxt = period_cnt + PERIOD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset forces a fresh AFE config pass.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cfg_pend    <= 1'b1;
      period_cnt  <= '0;
      period_q    <= PERIOD_MIN;
      samp_cnt    <= '0;
      line_open   <= 1'b0;
      line_cnt    <= '0;
      err_overrun <= 1'b0;
      sh_trig     <= 1'b0;
      cfg_start   <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cfg_pend    <= cfg_pend_nxt;
      period_cnt  <= period_cnt_nxt;
      period_q    <= period_q_nxt;
      samp_cnt    <= samp_cnt_nxt;
      line_open   <= line_open_nxt;
      line_cnt    <= line_cnt_nxt;
      err_overrun <= err_nxt;
      sh_trig     <= sh_nxt;
      cfg_start   <= cfg_start_nxt;
      line_done   <= line_done_nxt;
      frame_done  <= frame_done_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ccd_line_scheduler.sv
`timescale 1ns/1ps
// Bench for ccd_line_scheduler: directed acquisition scenarios with an event scoreboard.
module tb_ccd_line_scheduler;

  localparam int PW = 24;
  localparam int LW = 16;

  logic          sys_clk = 1'b0;
  logic          resetn  = 1'b1;
  logic          run = 1'b0;
  logic [PW-1:0] line_period = PW'(100);
  logic [LW-1:0] frame_lines = LW'(3);
  logic          cfg_req = 1'b0;
  logic          cfg_done = 1'b0;
  logic          samp_valid = 1'b0;
  logic          cfg_start, sh_trig, line_open, line_done, frame_done, err_overrun, busy;
  logic [LW-1:0] line_cnt;

  ccd_line_scheduler #(.SAMP_NUM(8), .PERIOD_W(PW), .LINES_W(LW)) dut (
    .sys_clk(sys_clk), .resetn(resetn), .run(run), .line_period(line_period),
    .frame_lines(frame_lines), .cfg_req(cfg_req), .cfg_done(cfg_done),
    .samp_valid(samp_valid), .cfg_start(cfg_start), .sh_trig(sh_trig),
    .line_open(line_open), .line_done(line_done), .frame_done(frame_done),
    .line_cnt(line_cnt), .err_overrun(err_overrun), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // kind: 0 cfg_start, 1 line_done (a=line_cnt b=frame_done c=err), 2 sh_trig (a=cycles since last sh, 0=first of a run; c=err)
  typedef struct { int kind; int a; int b; int c; } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_sh = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic take(input ev_t act, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d, want no event (cycle %0d)", nm, act.a, act.b, act.c, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == 2 && e.a == 0) act.a = 0;
      if (act.kind != e.kind || act.a != e.a || act.b != e.b || act.c != e.c) begin
        failures++;
        $display("FAIL event_%s: got kind=%0d a=%0d b=%0d c=%0d, want kind=%0d a=%0d b=%0d c=%0d (cycle %0d)",
                 nm, act.kind, act.a, act.b, act.c, e.kind, e.a, e.b, e.c, cyc);
      end
    end
  endtask

  // Monitor: every output pulse is matched against the next expected event.
  always @(negedge sys_clk) begin
    ev_t a;
    if (resetn) begin
      if (cfg_start) begin
        a.kind = 0; a.a = 0; a.b = 0; a.c = 0;
        take(a, "cfg_start");
      end
      if (line_done) begin
        a.kind = 1; a.a = int'(line_cnt); a.b = int'(frame_done); a.c = int'(err_overrun);
        take(a, "line_done");
      end
      if (frame_done && !line_done) begin
        checks++; failures++;
        $display("FAIL frame_done_alone: got frame_done=1 line_done=0, want both (cycle %0d)", cyc);
      end
      if (sh_trig) begin
        a.kind = 2; a.a = cyc - last_sh; a.b = 0; a.c = int'(err_overrun);
        take(a, "sh_trig");
        last_sh = cyc;
      end
    end
  end

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      samp_valid = 1'b1;
      step();
    end
    samp_valid = 1'b0;
  endtask

  task automatic pulse_cfg_done();
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
  endtask

  task automatic wait_sh();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (sh_trig) got = 1'b1;
    end
    chk("wait_sh", int'(got), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    // Reset state and initial config pass
    #3 resetn = 1'b0;
    stepn(2);
    chk("rst_outputs", int'({cfg_start, sh_trig, line_open, line_done, frame_done, err_overrun, busy}), 0);
    chk("rst_line_cnt", int'(line_cnt), 0);
    push(0, 0, 0, 0);
    resetn = 1'b1;
    stepn(52);
    chk("cfg_wait_busy", int'(busy), 1);
    pulse_cfg_done();
    chk("cfg_done_idle", int'(busy), 0);
    stepn(3);

    // Three-line frame, all lines complete
    push(2, 0, 0, 0);
    run = 1'b1;
    step();
    push(1, 1, 0, 0); send(8);
    push(2, 100, 0, 0); wait_sh();
    push(1, 2, 0, 0); send(8);
    push(2, 100, 0, 0); wait_sh();
    run = 1'b0;
    push(1, 3, 1, 0); send(8);
    stepn(120);
    chk("frame_line_cnt", int'(line_cnt), 3);
    chk("frame_err", int'(err_overrun), 0);
    chk("frame_idle", int'(busy), 0);

    // Short first line: overrun at the next trigger, later lines normal
    push(2, 0, 0, 0);
    run = 1'b1;
    step();
    send(5);
    push(2, 100, 0, 1); wait_sh();
    chk("ovr_err", int'(err_overrun), 1);
    chk("ovr_line_cnt", int'(line_cnt), 0);
    push(1, 1, 0, 1); send(8);
    push(2, 100, 0, 1); wait_sh();
    push(1, 2, 0, 1); send(8);
    push(2, 100, 0, 1); wait_sh();
    run = 1'b0;
    push(1, 3, 1, 1); send(8);
    stepn(120);
    chk("ovr_idle", int'(busy), 0);

    // Continuous mode, cfg_req mid-line: line finishes in DRAIN, then reconfig
    line_period = PW'(20);
    frame_lines = '0;
    push(2, 0, 0, 0);
    run = 1'b1;
    step();
    send(3);
    cfg_req = 1'b1; step(); cfg_req = 1'b0;
    stepn(20);
    chk("drain_busy", int'(busy), 1);
    chk("drain_line_open", int'(line_open), 1);
    push(1, 1, 0, 0);
    push(0, 0, 0, 0);
    send(5);
    stepn(5);
    chk("recfg_busy", int'(busy), 1);
    push(2, 0, 0, 0);
    pulse_cfg_done();
    wait_sh();
    chk("rerun_line_cnt", int'(line_cnt), 0);
    // Final sample lands on the wrap edge: old line completes, new line opens
    stepn(12);
    push(1, 1, 0, 0);
    push(2, 20, 0, 0);
    send(8);
    chk("coinc_line_open", int'(line_open), 1);
    chk("coinc_err", int'(err_overrun), 0);

    // run dropped with no samples: DRAIN times out
    run = 1'b0;
    stepn(30);
    chk("tmo_drain_busy", int'(busy), 1);
    chk("tmo_drain_err", int'(err_overrun), 0);
    stepn(15);
    chk("tmo_err", int'(err_overrun), 1);
    chk("tmo_idle", int'(busy), 0);
    chk("tmo_line_open", int'(line_open), 0);

    // Asynchronous reset mid-line, then config before any trigger
    push(2, 0, 0, 0);
    run = 1'b1;
    step();
    send(3);
    #2 resetn = 1'b0;
    #1;
    chk("arst_outputs", int'({cfg_start, sh_trig, line_open, line_done, frame_done, err_overrun, busy}), 0);
    chk("arst_line_cnt", int'(line_cnt), 0);
    stepn(3);
    push(0, 0, 0, 0);
    resetn = 1'b1;
    stepn(5);
    chk("arst_cfg_busy", int'(busy), 1);
    push(2, 0, 0, 0);
    pulse_cfg_done();
    wait_sh();
    run = 1'b0;
    push(1, 1, 0, 0); send(8);
    stepn(40);
    chk("end_idle", int'(busy), 0);
    chk("end_err", int'(err_overrun), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccd_line_scheduler.md
# ccd_line_scheduler

Acquisition sequencer for the linear-CCD front end. It configures the AFE through the serial config block, issues the per-line SH trigger to the CCD timing driver at a programmable line period, and counts AFE output samples to frame each line. It also reports line/frame completion and readout overruns. It sits between system control and the CCD driver / AD9945 config and driver blocks, all on the 100 MHz sensor clock.

## Interface
- SAMP_NUM, 2048: samples per line expected from the AFE driver.
- PERIOD_W, 24: width of line_period.
- LINES_W, 16: width of frame_lines and line_cnt.

- sys_clk  in  1  sensor/system clock.
- resetn  in  1  asynchronous, active-low reset.
- run  in  1  level; acquisition enable.
- line_period  in  PERIOD_W  sys_clk cycles between SH triggers; values <2 treated as 2.
- frame_lines  in  LINES_W  lines per frame; 0 = continuous.
- cfg_req  in  1  one-cycle request to reprogram the AFE.
- cfg_done  in  1  one-cycle pulse from the config block when the serial write finishes.
- samp_valid  in  1  AFE driver tvalid, one pulse per sample.
- cfg_start  out  1  one-cycle pulse that starts an AFE config write.
- sh_trig  out  1  one-cycle SH trigger to the CCD driver.
- line_open  out  1  high while the current line is collecting samples.
- line_done  out  1  one-cycle pulse when SAMP_NUM samples have been received.
- frame_done  out  1  one-cycle pulse on completion of the last line of a frame.
- line_cnt  out  LINES_W  lines completed since entering RUN.
- err_overrun  out  1  sticky; a line was not complete at the next SH trigger.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CFG, RUN, DRAIN. Reset: state IDLE, cfg_pend=1, all outputs 0, all counters 0.
- cfg_pend is set by cfg_req in any state. It is cleared on entering CFG.
- IDLE behaviour, with priority:
  - If cfg_pend is set, go to CFG.
  - Otherwise, if run is high, go to RUN. This clears line_cnt, err_overrun and period_cnt.
- CFG:
  - cfg_start pulses in the first cycle of CFG.
  - Wait for cfg_done, then go to IDLE.
  - cfg_done outside CFG is ignored.
- RUN, period counter:
  - period_cnt counts 0..line_period-1 and wraps.
  - sh_trig pulses in the first RUN cycle and at every wrap, i.e. exactly every line_period cycles.
  - line_period is sampled at each wrap.
- RUN, at each sh_trig:
  - If line_open is still 1, set err_overrun and discard the partial line (samp_cnt := 0).
  - Then set line_open := 1 and samp_cnt := 0.
- RUN, sample counting:
  - samp_valid with line_open=1 increments samp_cnt.
  - On the SAMP_NUM-th sample: line_done pulses, line_cnt increments, line_open := 0.
  - samp_valid with line_open=0 is ignored.
- Frame end: if frame_lines != 0 and line_cnt reaches frame_lines, frame_done pulses together with line_done. No further sh_trig is issued, and the state goes to IDLE.
- Stop: if run is low or cfg_pend is set at a wrap point, no sh_trig is issued and the state goes to DRAIN.
- DRAIN:
  - Sample counting continues.
  - Exit to IDLE when line_open falls, or after line_period cycles (timeout).
  - On timeout, set err_overrun and clear line_open.
- Counter widths: samp_cnt is clog2(SAMP_NUM+1) bits. line_cnt wraps modulo 2^LINES_W in continuous mode, with no error.
- Asynchronous reset mid-operation returns to the reset state and forces a fresh AFE config.

## Timing
- All outputs are registered.
- sh_trig is high in the cycle after the IDLE→RUN transition edge.
- line_done and frame_done are high in the cycle after the clock edge that samples the final samp_valid. line_cnt updates on the same edge.
- cfg_start is high in the cycle after the IDLE→CFG transition.
- After cfg_done, IDLE is reached in 1 cycle. RUN can be entered 1 cycle later.
- Simultaneous events:
  - Final samp_valid coincident with sh_trig: the sample completes the old line (line_done, no overrun), then the new line opens.
  - cfg_req coincident with cfg_done: cfg_pend stays set, so another CFG pass follows.

## Test plan
- Reset release → cfg_start pulses once. Hold cfg_done low for 50 cycles → busy=1, no sh_trig. cfg_done → busy=0.
- SAMP_NUM=8, line_period=100, frame_lines=3, run=1, 8 samp_valid per line within the period → sh_trig at t0, t0+100, t0+200. Three line_done pulses, line_cnt=3, frame_done with the third, err_overrun=0, back to IDLE.
- Same setup but only 5 samples in line 1 → err_overrun=1 at the second sh_trig, line_cnt does not count line 1, later lines complete normally.
- frame_lines=0, cfg_req mid-line → current line finishes in DRAIN, IDLE, cfg_start pulse, then RUN resumes with line_cnt=0.
- run dropped with no samples arriving → DRAIN times out after line_period cycles, err_overrun=1, IDLE.
- resetn low mid-line → all outputs 0 immediately. On release, cfg_start pulses before any sh_trig.
